sha256_msg_sequencer: RTL and testbench

//  Streams a word-aligned message into sha256_core and drives all of the core's control.
//  - Packs 32-bit words into 512-bit blocks and applies SHA-256 padding and the bit length.
//  - Issues init for block 0 and next for every later block, then captures the final digest.
//  - Sits between a DMA/stream source and sha256_core, replacing per-word software control.

---
 rtl/sha256_msg_sequencer_if.sv | 21 ++
 rtl/sha256_msg_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_sha256_msg_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_sequencer_if.sv
`timescale 1ns/1ps
// sha256_msg_sequencer_if
//   Word stream from a DMA/stream source into sha256_msg_sequencer.
//   Handshake: a word transfers on a rising clk edge where s_valid and s_ready
//   are both high. s_valid, s_data and s_last must be held stable by the
//   master until that edge; s_ready may change without regard to s_valid.
//   s_last is only meaningful while s_valid is high.
//   Signals:
//     s_valid  master->slave  word present
//     s_data   master->slave  32-bit word, big-endian (first byte in [31:24])
//     s_last   master->slave  final word of the message
//     s_ready  slave->master  word can be taken this cycle
interface sha256_msg_sequencer_if;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_last;
   logic        s_ready;

   modport master (output s_valid, output s_data, output s_last, input s_ready);
   modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/sha256_msg_sequencer.sv
`timescale 1ns/1ps
// sha256_msg_sequencer
//   Packs a word-aligned message into 512-bit blocks, applies SHA-256 padding
//   and the 64-bit bit length, drives init/next of sha256_core and captures
//   the final digest.
//   Ports:
//     clk, reset         clock (rising edge), synchronous active-high reset
//     s                  word stream (slave side of sha256_msg_sequencer_if)
//     core_init/next     one-cycle block start pulses to the core
//     core_mode          always 1 (SHA-256)
//     core_block         current block, word 0 in [511:480]
//     core_ready         core idle
//     core_digest(_valid) core result
//     digest(_valid)     captured final digest, held until the next message
//     busy               high outside IDLE and DONE
//     state_dbg          current FSM state encoding
module sha256_msg_sequencer #(
   parameter int WCNT_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   sha256_msg_sequencer_if.slave  s,
   output logic                   core_init,
   output logic                   core_next,
   output logic                   core_mode,
   output logic [511:0]           core_block,
   input  logic                   core_ready,
   input  logic [255:0]           core_digest,
   input  logic                   core_digest_valid,
   output logic [255:0]           digest,
   output logic                   digest_valid,
   output logic                   busy,
   output logic [2:0]             state_dbg
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_PAD, ST_ISSUE, ST_SETTLE, ST_WAIT, ST_DONE
   } state_t;

   state_t             state, state_next;
   logic [31:0]        blk_buf [16];
   logic [4:0]         idx;
   logic [WCNT_W-1:0]  wcnt;
   logic [WCNT_W-1:0]  blk_cnt;
   logic               final_q;
   logic               pad_pending;
   logic               len_pending;
   logic               accept;
   logic [63:0]        len64;

   // Message length in bits: words * 32.
   assign len64     = {{(59-WCNT_W){1'b0}}, wcnt, 5'b0};
   assign core_mode = 1'b1;
   assign state_dbg = state;

   always_comb begin
      core_block = '0;
      for (int i = 0; i < 16; i++) begin
         core_block[511-32*i -: 32] = blk_buf[i];
      end
   end

   always_comb begin
      state_next = state;
      s.s_ready  = 1'b0;
      busy       = 1'b1;
      accept     = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            s.s_ready = 1'b1;
            busy      = 1'b0;
            accept    = s.s_valid;
            if (s.s_valid) state_next = s.s_last ? ST_PAD : ST_LOAD;
         end
         ST_LOAD: begin
            s.s_ready = 1'b1;
            accept    = s.s_valid;
            if (s.s_valid) begin
               // A full buffer goes straight to the core; padding follows
               // in a later block when this was also the last word.
               if (idx == 5'd15)  state_next = ST_ISSUE;
               else if (s.s_last) state_next = ST_PAD;
            end
         end
         ST_PAD:    state_next = ST_ISSUE;
         ST_ISSUE:  if (core_ready) state_next = ST_SETTLE;
         // core_ready may still be high from before the pulse was seen.
         ST_SETTLE: state_next = ST_WAIT;
         ST_WAIT: begin
            if (core_ready) begin
               if (final_q) begin
                  if (core_digest_valid) state_next = ST_DONE;
               end else if (pad_pending || len_pending) begin
                  state_next = ST_ISSUE;
               end else begin
                  state_next = ST_LOAD;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         idx          <= '0;
         wcnt         <= '0;
         blk_cnt      <= '0;
         final_q      <= 1'b0;
         pad_pending  <= 1'b0;
         len_pending  <= 1'b0;
         core_init    <= 1'b0;
         core_next    <= 1'b0;
         digest       <= '0;
         digest_valid <= 1'b0;
         for (int i = 0; i < 16; i++) blk_buf[i] <= '0;
      end else begin
         state     <= state_next;
         core_init <= 1'b0;
         core_next <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  blk_buf[0]   <= s.s_data;
                  idx          <= 5'd1;
                  wcnt         <= WCNT_W'(1);
                  blk_cnt      <= '0;
                  final_q      <= 1'b0;
                  pad_pending  <= 1'b0;
                  len_pending  <= 1'b0;
                  digest_valid <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  blk_buf[idx[3:0]] <= s.s_data;
                  idx               <= idx + 5'd1;
                  wcnt              <= wcnt + WCNT_W'(1);
                  if (s.s_last && idx == 5'd15) pad_pending <= 1'b1;
               end
            end
            ST_PAD: begin
               // idx points at the first unused word.
               for (int i = 0; i < 16; i++) begin
                  if (5'(i) == idx) begin
                     blk_buf[i] <= 32'h8000_0000;
                  end else if (5'(i) > idx) begin
                     if (idx <= 5'd13 && i == 14)      blk_buf[i] <= len64[63:32];
                     else if (idx <= 5'd13 && i == 15) blk_buf[i] <= len64[31:0];
                     else                              blk_buf[i] <= '0;
                  end
               end
               if (idx <= 5'd13) final_q     <= 1'b1;
               else              len_pending <= 1'b1;
            end
            ST_ISSUE: begin
               if (core_ready) begin
                  core_init <= (blk_cnt == '0);
                  core_next <= (blk_cnt != '0);
                  blk_cnt   <= blk_cnt + WCNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (core_ready) begin
                  if (final_q) begin
                     if (core_digest_valid) begin
                        digest       <= core_digest;
                        digest_valid <= 1'b1;
                     end
                  end else if (pad_pending) begin
                     blk_buf[0] <= 32'h8000_0000;
                     for (int i = 1; i < 14; i++) blk_buf[i] <= '0;
                     blk_buf[14] <= len64[63:32];
                     blk_buf[15] <= len64[31:0];
                     final_q     <= 1'b1;
                     pad_pending <= 1'b0;
                  end else if (len_pending) begin
                     for (int i = 0; i < 14; i++) blk_buf[i] <= '0;
                     blk_buf[14] <= len64[63:32];
                     blk_buf[15] <= len64[31:0];
                     final_q     <= 1'b1;
                     len_pending <= 1'b0;
                  end else begin
                     idx <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
`timescale 1ns/1ps
// tb_sha256_msg_sequencer
//   Directed bench for sha256_msg_sequencer with a behavioural SHA-256 core.
module tb_sha256_msg_sequencer;

   localparam logic [255:0] H0 =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] ABCD_DIGEST =
      256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;
   localparam logic [511:0] ABCD_BLOCK =
      {32'h61626364, 32'h80000000, 416'h0, 32'h00000020};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sha256_msg_sequencer_if sif();

   logic         core_init, core_next, core_mode;
   logic [511:0] core_block;
   logic         core_ready;
   logic [255:0] core_digest = '0;
   logic         core_digest_valid = 1'b0;
   logic [255:0] digest;
   logic         digest_valid, busy;
   logic [2:0]   state_dbg;

   sha256_msg_sequencer #(.WCNT_W(32)) dut (
      .clk               (clk),
      .reset             (reset),
      .s                 (sif),
      .core_init         (core_init),
      .core_next         (core_next),
      .core_mode         (core_mode),
      .core_block        (core_block),
      .core_ready        (core_ready),
      .core_digest       (core_digest),
      .core_digest_valid (core_digest_valid),
      .digest            (digest),
      .digest_valid      (digest_valid),
      .busy              (busy),
      .state_dbg         (state_dbg)
   );

   // ---------------- behavioural SHA-256 core ----------------
   logic [31:0] k_tab [64];
   initial k_tab = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      {a, b, c, d, e, f, g, h} = hin;
      for (int i = 0; i < 64; i++) begin
         s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
         t1 = h + s1 + ((e & f) ^ (~e & g)) + k_tab[i] + w[i];
         s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
         t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1;
         d = c; c = b; b = a; a = t1 + t2;
      end
      return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
              e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
   endfunction

   logic         core_ready_q = 1'b1;
   logic         core_hold = 1'b0;
   int           core_lat = 4;
   int           core_cnt = 0;
   logic [255:0] h_state = '0;

   assign core_ready = core_ready_q && !core_hold;

   always @(posedge clk) begin
      if (core_init || core_next) begin
         h_state           <= sha_compress(core_init ? H0 : h_state, core_block);
         core_ready_q      <= 1'b0;
         core_digest_valid <= 1'b0;
         core_cnt          <= core_lat;
      end else if (!core_ready_q) begin
         if (core_cnt == 0) begin
            core_ready_q      <= 1'b1;
            core_digest_valid <= 1'b1;
            core_digest       <= h_state;
         end else begin
            core_cnt <= core_cnt - 1;
         end
      end
   end

   // ---------------- pulse monitor ----------------
   logic [511:0] got_q [$];
   int n_init = 0, n_next = 0, n_both = 0;

   always @(negedge clk) begin
      if (core_init || core_next) got_q.push_back(core_block);
      if (core_init) n_init++;
      if (core_next) n_next++;
      if (core_init && core_next) n_both++;
   end

   // ---------------- scoreboard ----------------
   logic [511:0] exp_q [$];
   logic [31:0]  msg_q [$];
   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_blocks(input string tag, input int base);
      logic [511:0] e;
      int k;
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (base + k < got_q.size()) check($sformatf("%s_blk%0d", tag, k), got_q[base + k], e);
         else                         check($sformatf("%s_blk%0d_missing", tag, k), 0, 1);
         k++;
      end
      check({tag, "_blk_count"}, got_q.size() - base, k);
   endtask

   // ---------------- driver ----------------
   task automatic send_words(input int from, input int to, input bit with_last);
      for (int i = from; i < to; i++) begin
         int guard;
         guard = 0;
         sif.s_valid = 1'b1;
         sif.s_data  = msg_q[i];
         sif.s_last  = with_last && (i == to - 1);
         while (!sif.s_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 2000) begin
            check("s_ready_wait", 0, 1);
            break;
         end
         @(posedge clk);
         @(negedge clk);
      end
      sif.s_valid = 1'b0;
      sif.s_last  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!digest_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, digest_valid, 1);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic load_abcd();
      msg_q.delete();
      msg_q.push_back(32'h61626364);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base, i0, n0, bad_rdy, bad_blk, pulses;
      logic [511:0] blk, snap;

      reset = 1'b1;
      sif.s_valid = 1'b0;
      sif.s_data  = '0;
      sif.s_last  = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_s_ready", sif.s_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_init", core_init, 0);
      check("rst_next", core_next, 0);
      check("rst_mode", core_mode, 1);
      check("rst_block", core_block, 0);
      check("rst_digest", digest, 0);
      check("rst_dvalid", digest_valid, 0);
      reset = 1'b0;
      @(negedge clk);

      // One-word message "abcd"
      base = got_q.size(); i0 = n_init; n0 = n_next;
      load_abcd();
      exp_q.push_back(ABCD_BLOCK);
      send_words(0, 1, 1);
      wait_done("abcd");
      check("abcd_digest", digest, ABCD_DIGEST);
      check("abcd_inits", n_init - i0, 1);
      check("abcd_nexts", n_next - n0, 0);
      check_blocks("abcd", base);

      // 14 words: pad word at idx 14, length in a second block
      base = got_q.size(); i0 = n_init; n0 = n_next;
      msg_q.delete();
      for (int i = 0; i < 14; i++) msg_q.push_back(32'h1000_0000 + i);
      blk = '0;
      for (int i = 0; i < 14; i++) blk[511-32*i -: 32] = msg_q[i];
      blk[511-32*14 -: 32] = 32'h8000_0000;
      exp_q.push_back(blk);
      exp_q.push_back({480'h0, 32'h0000_01c0});
      check("w14_prev_dvalid", digest_valid, 1);
      check("w14_prev_digest", digest, ABCD_DIGEST);
      send_words(0, 1, 0);
      check("w14_dvalid_drop", digest_valid, 0);
      send_words(1, 14, 1);
      wait_done("w14");
      check("w14_digest", digest, core_digest);
      check("w14_inits", n_init - i0, 1);
      check("w14_nexts", n_next - n0, 1);
      check_blocks("w14", base);

      // 16 words: full block, then pad + length block
      base = got_q.size();
      msg_q.delete();
      for (int i = 0; i < 16; i++) msg_q.push_back(32'h2000_0000 + i * 7);
      blk = '0;
      for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = msg_q[i];
      exp_q.push_back(blk);
      exp_q.push_back({32'h8000_0000, 448'h0, 32'h0000_0200});
      send_words(0, 16, 1);
      bad_rdy = 0;
      for (int n = 0; n < 3000 && !digest_valid; n++) begin
         if (sif.s_ready) bad_rdy++;
         @(negedge clk);
      end
      check("w16_s_ready_low", bad_rdy, 0);
      wait_done("w16");
      check_blocks("w16", base);

      // core_ready held low in ISSUE
      base = got_q.size(); i0 = n_init; n0 = n_next;
      core_hold = 1'b1;
      load_abcd();
      exp_q.push_back(ABCD_BLOCK);
      send_words(0, 1, 1);
      repeat (2) @(negedge clk);
      snap = core_block;
      bad_blk = 0; pulses = 0;
      for (int n = 0; n < 100; n++) begin
         if (core_block !== snap) bad_blk++;
         if (core_init || core_next) pulses++;
         @(negedge clk);
      end
      check("hold_no_pulse", pulses, 0);
      check("hold_block_stable", bad_blk, 0);
      check("hold_block", core_block, ABCD_BLOCK);
      core_hold = 1'b0;
      @(negedge clk);
      check("hold_pulse_after_ready", core_init, 1);
      wait_done("hold");
      check("hold_digest", digest, ABCD_DIGEST);
      check("hold_inits", n_init - i0, 1);
      check_blocks("hold", base);

      // Reset while waiting on block 1 of a longer message
      base = got_q.size(); i0 = n_init;
      core_lat = 30;
      msg_q.delete();
      for (int i = 0; i < 16; i++) msg_q.push_back(32'h3000_0000 ^ (i << 8));
      blk = '0;
      for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = msg_q[i];
      exp_q.push_back(blk);
      send_words(0, 16, 0);
      for (int n = 0; n < 200 && n_init == i0; n++) @(negedge clk);
      check("rstw_init_seen", n_init - i0, 1);
      repeat (3) @(negedge clk);
      check("rstw_busy_before", busy, 1);
      check_blocks("rstw", base);
      reset = 1'b1;
      @(negedge clk);
      check("rstw_s_ready", sif.s_ready, 1);
      check("rstw_busy", busy, 0);
      check("rstw_init", core_init | core_next, 0);
      check("rstw_dvalid", digest_valid, 0);
      check("rstw_digest", digest, 0);
      check("rstw_block", core_block, 0);
      reset = 1'b0;
      core_lat = 4;
      @(negedge clk);
      base = got_q.size(); i0 = n_init; n0 = n_next;
      load_abcd();
      exp_q.push_back(ABCD_BLOCK);
      send_words(0, 1, 1);
      wait_done("rstw_abcd");
      check("rstw_abcd_digest", digest, ABCD_DIGEST);
      check("rstw_abcd_inits", n_init - i0, 1);
      check("rstw_abcd_nexts", n_next - n0, 0);
      check_blocks("rstw_abcd", base);

      check("init_next_exclusive", n_both, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
